// File: rtl/traffic_pkg.sv
// Shared types and default sizing for the traffic sensor front end.
package traffic_pkg;

    typedef enum logic [1:0] {
        E_IDLE,
        E_ACTIVE,
        E_HOLD,
        E_FAULT
    } emerg_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 4;
    localparam int DEF_EMERG_HOLD  = 8;
    localparam int DEF_EMERG_MAX   = 1024;

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Raw detector inputs, controller greens and conditioned requests between the
// street side and traffic_light_controller.
interface traffic_sensor_conditioner_if;

    logic car_a_raw;
    logic car_b_raw;
    logic emerg_raw;
    logic ga_in;
    logic gb_in;
    logic Sa;
    logic Sb;
    logic emergency;
    logic emerg_fault;

    modport master (
        output car_a_raw, car_b_raw, emerg_raw, ga_in, gb_in,
        input  Sa, Sb, emergency, emerg_fault
    );

    modport slave (
        input  car_a_raw, car_b_raw, emerg_raw, ga_in, gb_in,
        output Sa, Sb, emergency, emerg_fault
    );

endinterface

// File: rtl/sensor_debounce.sv
// Synchronizer chain followed by a stability counter; db only follows the
// synchronized input once it has differed for DB_CYCLES consecutive cycles.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CNT_W = $clog2(DB_CYCLES) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync_val;

    assign sync_val = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt    <= '0;
            db     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (sync_val == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions car detectors into sticky Sa/Sb requests and the emergency receiver
// into a held pre-emption. Optional stuck-emergency timeout: EMERG_TIMEOUT_EN.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int EMERG_HOLD  = DEF_EMERG_HOLD,
    parameter int EMERG_MAX   = DEF_EMERG_MAX
) (
    input  logic                        clk,
    input  logic                        reset,
    traffic_sensor_conditioner_if.slave bus
);

    localparam int HOLD_W = $clog2(EMERG_HOLD) + 1;

    if (SYNC_STAGES < 2 || DB_CYCLES < 1 || EMERG_HOLD < 1 || EMERG_MAX < 2) begin : g_param_check
        $error("traffic_sensor_conditioner: illegal parameter value");
    end

    logic db_a, db_b, db_e;
    logic db_a_q, db_b_q;
    logic sa_q, sb_q;

    emerg_state_t      state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_a (
        .clk(clk), .reset(reset), .raw(bus.car_a_raw), .db(db_a)
    );
    sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_b (
        .clk(clk), .reset(reset), .raw(bus.car_b_raw), .db(db_b)
    );
    sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_e (
        .clk(clk), .reset(reset), .raw(bus.emerg_raw), .db(db_e)
    );

    // A green clears its lane even if a new car edge lands on the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_a_q <= 1'b0;
            db_b_q <= 1'b0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
        end else begin
            db_a_q <= db_a;
            db_b_q <= db_b;
            if (bus.ga_in)
                sa_q <= 1'b0;
            else if (db_a && !db_a_q)
                sa_q <= 1'b1;
            if (bus.gb_in)
                sb_q <= 1'b0;
            else if (db_b && !db_b_q)
                sb_q <= 1'b1;
        end
    end

`ifdef EMERG_TIMEOUT_EN
    localparam int ACT_W = $clog2(EMERG_MAX) + 1;
    logic [ACT_W-1:0] active_cnt, active_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= E_IDLE;
            hold_cnt <= '0;
`ifdef EMERG_TIMEOUT_EN
            active_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
`ifdef EMERG_TIMEOUT_EN
            active_cnt <= active_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
`ifdef EMERG_TIMEOUT_EN
        active_nxt = active_cnt;
`endif
        case (state)
            E_IDLE: begin
                if (db_e) begin
                    state_nxt = E_ACTIVE;
`ifdef EMERG_TIMEOUT_EN
                    active_nxt = '0;
`endif
                end
            end
            E_ACTIVE: begin
                if (!db_e) begin
                    state_nxt = E_HOLD;
                    hold_nxt  = HOLD_W'(EMERG_HOLD - 1);
                end
`ifdef EMERG_TIMEOUT_EN
                else if (active_cnt == ACT_W'(EMERG_MAX - 1))
                    state_nxt = E_FAULT;
                else
                    active_nxt = active_cnt + ACT_W'(1);
`endif
            end
            E_HOLD: begin
                if (db_e) begin
                    state_nxt = E_ACTIVE;
`ifdef EMERG_TIMEOUT_EN
                    active_nxt = '0;
`endif
                end else if (hold_cnt == '0) begin
                    state_nxt = E_IDLE;
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
`ifdef EMERG_TIMEOUT_EN
            E_FAULT: begin
                if (!db_e)
                    state_nxt = E_IDLE;
            end
`endif
            default: state_nxt = E_IDLE;
        endcase
    end

    assign bus.Sa        = sa_q;
    assign bus.Sb        = sb_q;
    assign bus.emergency = (state == E_ACTIVE) || (state == E_HOLD);
`ifdef EMERG_TIMEOUT_EN
    assign bus.emerg_fault = (state == E_FAULT);
`else
    assign bus.emerg_fault = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Scoreboard bench: each scenario pushes the expected {Sa,Sb,emergency,emerg_fault}
// per edge, then compares it one time unit after that edge.
module tb_traffic_sensor_conditioner;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] got;
    logic [3:0] exp;

    traffic_sensor_conditioner_if bus ();

    traffic_sensor_conditioner #(
        .SYNC_STAGES(2),
        .DB_CYCLES(4),
        .EMERG_HOLD(8),
        .EMERG_MAX(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ca, input logic cb, input logic em,
                                 input logic ga, input logic gb);
        bus.car_a_raw = ca;
        bus.car_b_raw = cb;
        bus.emerg_raw = em;
        bus.ga_in     = ga;
        bus.gb_in     = gb;
    endtask

    // Leaves the bench one time unit after "edge 0" with a clean DUT.
    task automatic do_reset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            applyStimulus(1, 1, 1, 1, 1);
            exp_q.push_back(4'b0000);
            step();
            got = {bus.Sa, bus.Sb, bus.emergency, bus.emerg_fault};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL reset edge %0d: got %b expected %b (Sa,Sb,emergency,emerg_fault)", e, got, exp);
            end
        end
        reset = 1'b0;
    endtask

    // Latency, green clear, no re-latch while held, and clear winning over set.
    task automatic test_car_request();
        logic ca, ga;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            ca = (e <= 16) || (e >= 25);
            ga = (e == 11) || (e >= 25 && e <= 35);
            applyStimulus(ca, 0, 0, ga, 0);
            exp_q.push_back({(e >= 7 && e <= 10), 3'b000});
            step();
            got = {bus.Sa, bus.Sb, bus.emergency, bus.emerg_fault};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL car_request edge %0d: got %b expected %b (Sa,Sb,emergency,emerg_fault)", e, got, exp);
            end
        end
    endtask

    // Pulses of 2 and 3 cycles are dropped; a 4-cycle pulse is accepted and sticks.
    task automatic test_glitch_reject();
        logic cb, gb;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            cb = (e <= 2) || (e >= 11 && e <= 13) || (e >= 23 && e <= 26);
            gb = (e == 35);
            applyStimulus(0, cb, 0, 0, gb);
            exp_q.push_back({1'b0, (e >= 29 && e <= 34), 2'b00});
            step();
            got = {bus.Sa, bus.Sb, bus.emergency, bus.emerg_fault};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL glitch_reject edge %0d: got %b expected %b (Sa,Sb,emergency,emerg_fault)", e, got, exp);
            end
        end
    endtask

    task automatic test_emergency_hold();
        logic em;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            applyStimulus(0, 0, (e <= 20), 0, 0);
            exp_q.push_back({2'b00, (e >= 7 && e <= 34), 1'b0});
            step();
            got = {bus.Sa, bus.Sb, bus.emergency, bus.emerg_fault};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL emergency_hold edge %0d: got %b expected %b (Sa,Sb,emergency,emerg_fault)", e, got, exp);
            end
        end
        // Re-assertion while holding must keep emergency continuously high.
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            em = (e <= 10) || (e >= 17 && e <= 30);
            applyStimulus(0, 0, em, 0, 0);
            exp_q.push_back({2'b00, (e >= 7 && e <= 44), 1'b0});
            step();
            got = {bus.Sa, bus.Sb, bus.emergency, bus.emerg_fault};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL emergency_reassert edge %0d: got %b expected %b (Sa,Sb,emergency,emerg_fault)", e, got, exp);
            end
        end
    endtask

    task automatic test_emergency_timeout();
        logic em_exp, flt_exp;
        do_reset();
        for (int e = 1; e <= 100; e++) begin
            applyStimulus(0, 0, (e <= 80), 0, 0);
`ifdef EMERG_TIMEOUT_EN
            em_exp  = (e >= 7 && e <= 70);
            flt_exp = (e >= 71 && e <= 86);
`else
            em_exp  = (e >= 7 && e <= 94);
            flt_exp = 1'b0;
`endif
            exp_q.push_back({2'b00, em_exp, flt_exp});
            step();
            got = {bus.Sa, bus.Sb, bus.emergency, bus.emerg_fault};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL emergency_timeout edge %0d: got %b expected %b (Sa,Sb,emergency,emerg_fault)", e, got, exp);
            end
        end
    endtask

    // Reset lands while Sa is latched and the FSM is in its hold phase.
    task automatic test_mid_reset();
        logic on;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            reset = (e == 20);
            if (e >= 20)
                applyStimulus(0, 0, 0, 0, 0);
            else
                applyStimulus(1, 0, (e <= 10), 0, 0);
            on = (e >= 7 && e <= 19);
            exp_q.push_back({on, 1'b0, on, 1'b0});
            step();
            got = {bus.Sa, bus.Sb, bus.emergency, bus.emerg_fault};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL mid_reset edge %0d: got %b expected %b (Sa,Sb,emergency,emerg_fault)", e, got, exp);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        $display("[TB] starting traffic_sensor_conditioner bench");
        test_reset();
        test_car_request();
        test_glitch_reject();
        test_emergency_hold();
        test_emergency_timeout();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
Upstream front end for traffic_light_controller. It takes the raw, asynchronous, bouncy inputs from the street-side car detectors and the emergency-vehicle receiver and turns them into clean, registered control inputs: Sa, Sb and emergency. Car detections are latched as sticky "car waiting" requests, which are cleared when the controller grants green to that lane. Emergency is given a minimum hold time after release so the controller never sees a glitching pre-emption.

Parameters:
SYNC_STAGES, 2, flip-flop synchronizer depth per raw input (>=2).
DB_CYCLES, 4, consecutive stable synchronized cycles needed to accept a level change (>=1).
EMERG_HOLD, 8, cycles emergency stays asserted after the debounced emergency input falls (>=1).
EMERG_MAX, 1024, stuck-emergency timeout in cycles; used only with EMERG_TIMEOUT_EN.

Ports:
clk  input  1  system clock; all state is updated on the rising edge.
reset  input  1  synchronous, active-high reset.
car_a_raw  input  1  raw lane-A car detector, asynchronous.
car_b_raw  input  1  raw lane-B car detector, asynchronous.
emerg_raw  input  1  raw emergency receiver, asynchronous.
ga_in  input  1  lane-A green from the controller; clears the A request.
gb_in  input  1  lane-B green from the controller; clears the B request.
Sa  output  1  lane-A car-waiting request, registered.
Sb  output  1  lane-B car-waiting request, registered.
emergency  output  1  conditioned emergency pre-emption, registered.
emerg_fault  output  1  stuck-emergency flag; tied to 0 when the macro is absent.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- On reset:
  - all synchronizer flops, debounced levels, counters and Sa/Sb/emergency/emerg_fault go to 0;
  - the emergency FSM goes to E_IDLE.
- Synchronize: each raw input passes through SYNC_STAGES flops.
- Debounce (per input):
  - The block holds a debounced level db and a counter.
  - If the synchronized value equals db, the counter is cleared.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1, db toggles and the counter is cleared on the same edge.
  - Any return to db before that resets the counter.
  - db changes SYNC_STAGES+DB_CYCLES edges after the first edge that samples a new stable raw value.
  - Pulses shorter than DB_CYCLES synchronized cycles are rejected.
- Request latch (Sa shown; Sb is identical with db_b/gb_in):
  - Set on a db_a rising edge (db_a=1 and previous db_a=0).
  - Cleared on any cycle where ga_in=1.
  - If set and clear occur in the same cycle, clear wins: a car arriving during green is served by that green.
  - While set, Sa holds regardless of db_a.
  - Sa updates one edge after the db_a rise.
- Emergency FSM (states in traffic_pkg):
  - E_IDLE: emergency=0. Go to E_ACTIVE when db_e=1.
  - E_ACTIVE: emergency=1. Go to E_HOLD when db_e=0, loading hold_cnt=EMERG_HOLD-1.
  - E_HOLD: emergency=1.
    - If db_e=1, return to E_ACTIVE; hold_cnt restarts on the next release.
    - Else, if hold_cnt==0, go to E_IDLE.
    - Else, decrement hold_cnt.
  - emergency is decoded from the state register, so it asserts one edge after db_e rises and is held for exactly EMERG_HOLD cycles after db_e falls.
- Counter widths: each counter is $clog2 of its maximum value plus 1, with no wrap. Counters saturate or clear as described above and never roll over.
- Mid-operation reset: all latched requests and the emergency state are discarded. Outputs are 0 on the edge after reset is sampled.

Optional Feature:
EMERG_TIMEOUT_EN
- Defined:
  - An active_cnt counts cycles spent in E_ACTIVE; it is cleared on entry.
  - When active_cnt reaches EMERG_MAX-1, the FSM goes to E_FAULT.
  - In E_FAULT: emergency=0 and emerg_fault=1.
  - E_FAULT is left for E_IDLE only when db_e=0; emerg_fault clears on that same edge.
- Undefined: no E_FAULT state, no active_cnt, and emerg_fault is tied to 0.

Decomposition:
- traffic_pkg holds:
  - the emergency state enum (E_IDLE, E_ACTIVE, E_HOLD, E_FAULT);
  - default constants for SYNC_STAGES, DB_CYCLES and EMERG_HOLD.
- One sub-module, sensor_debounce, contains the synchronizer plus debounce counter, with parameters SYNC_STAGES and DB_CYCLES and output db. It is instantiated three times.

Test Plan:
- Reset, then car_a_raw=1 held → Sa=0 until edge 7 (2+4+1 after the first sampling edge), then Sa=1; Sb and emergency stay 0.
- car_b_raw glitch high for 2 cycles, then low → Sb never asserts; the debounced value stays 0.
- Sa=1, then ga_in=1 for 1 cycle → Sa=0 on the next edge. With car_a_raw still held high, Sa stays 0 (no new rising edge).
- emerg_raw high for 20 cycles, then low → emergency rises 7 edges after the first sample, stays high, and falls exactly 8 cycles after db_e falls. A re-assertion during E_HOLD keeps emergency continuously high.
- With EMERG_TIMEOUT_EN and EMERG_MAX=64, emerg_raw held high → emergency drops and emerg_fault=1 after 64 cycles in E_ACTIVE. Releasing emerg_raw returns the FSM to E_IDLE and clears emerg_fault after the debounce delay.
- Reset asserted for 1 cycle while Sa=1 and emergency=1 (E_HOLD) → Sa=0, emergency=0 and the FSM is in E_IDLE on the next edge.
